mem_sched: RTL and testbench
============================

# mem_sched

Nibble-serial memory scheduler sitting between the instruction cache, the CPU data port and the single 4-bit external memory engine. It arbitrates line fills requested by the icache (`pull`/`tag`) against 16-bit data loads and stores, drives the memory engine's command interface, and steers returned nibbles either into the icache fill path (`dread`/`wstrobe_d`) or into a 16-bit data assembly register. Exactly one transfer is in flight at a time; each one runs to completion once granted.

## Interface

- `LINE_LENGTH`, 4: icache line length in bytes; a fill is `LINE_LENGTH*2` nibbles.
- `PA`, 22: physical address width; addresses are halfword addresses `[PA-1:1]`.
- `NW`, `$clog2(LINE_LENGTH*2)+1`: width of nibble count fields (derived; do not override).

- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ic_pull`  in  1  icache miss, line fill wanted.
- `ic_tag`  in  `[PA-1:$clog2(LINE_LENGTH)]`  line address of the miss.
- `ic_busy`  out  1  fill granted and in progress; fetch must hold `paddr` stable.
- `ic_dread`  out  4  fill nibble to icache.
- `ic_wstrobe`  out  1  fill nibble valid (icache `wstrobe_d`).
- `d_req`  in  1  data access request, held until `d_ack`.
- `d_addr`  in  `[PA-1:1]`  halfword address.
- `d_write`  in  1  1 = store, 0 = load.
- `d_wdata`  in  16  store data.
- `d_rdata`  out  16  load data, valid from `d_ack`, held until next load completes.
- `d_ack`  out  1  one-cycle completion pulse.
- `bus_start`  out  1  one-cycle command strobe to memory engine.
- `bus_addr`  out  `[PA-1:1]`  start halfword address.
- `bus_write`  out  1  command direction.
- `bus_len`  out  `NW`  nibble count (`LINE_LENGTH*2` or 4).
- `bus_wdata`  out  4  current store nibble.
- `bus_rdata`  in  4  returned nibble.
- `bus_nib`  in  1  one nibble transferred this cycle (read data valid or write nibble consumed).

## Operation

- States: IDLE, ISSUE, IFILL, DREAD, DWRITE, DONE.
- IDLE: if any request, grant and go ISSUE. Arbitration: round-robin with 1-bit `last` (0 = icache, 1 = data). Both pending -> grant the one not equal to `last`. Single pending -> grant it. `last` updated on every grant; reset value 1 (icache wins first tie).
- Grant latches the command: icache -> `bus_addr = {ic_tag, 0…}` (line-aligned), `bus_write=0`, `bus_len=LINE_LENGTH*2`; data -> `bus_addr=d_addr`, `bus_write=d_write`, `bus_len=4`, `d_wdata` copied into a 16-bit shift register.
- ISSUE: `bus_start=1` for exactly this cycle; next state IFILL/DREAD/DWRITE. `bus_addr`, `bus_write`, `bus_len` held constant from ISSUE until leaving DONE.
- Nibble counter `cnt` (NW bits) cleared at grant, +1 per cycle with `bus_nib=1` in a transfer state. Nibble order is little-endian: nibble N = bits `[4N+3:4N]`, ascending address.
- IFILL: `ic_wstrobe = bus_nib`, `ic_dread = bus_rdata` (combinational passthrough, no added latency). `ic_busy=1` from grant through DONE.
- DREAD: on `bus_nib`, `bus_rdata` written into nibble `cnt` of `d_rdata`.
- DWRITE: `bus_wdata` = shift register `[3:0]`; on `bus_nib` shift right 4.
- Transfer state exits to DONE on the cycle `bus_nib=1` with `cnt == bus_len-1`.
- DONE: data transfer -> `d_ack=1`; icache -> nothing extra (icache sets valid on last strobe). Next IDLE. Requests are not sampled in DONE.
- `ic_pull` dropping mid-fill is ignored; fill completes. `d_req` must stay high until `d_ack`.
- `bus_nib` outside IFILL/DREAD/DWRITE is ignored.

## Timing

- Reset (asserted, async): state IDLE, `cnt=0`, `last=1`, `d_rdata=0`, shift register 0; all outputs 0 (`ic_busy`, `ic_wstrobe`, `ic_dread`, `d_ack`, `bus_start`, `bus_addr`, `bus_write`, `bus_len`, `bus_wdata`). Reset mid-transfer abandons it; no `d_ack`, no further `ic_wstrobe`.
- Request seen in IDLE at cycle T -> `bus_start` at T+1 -> first nibble accepted no earlier than T+2.
- Last nibble at cycle L -> `d_ack` (or `ic_busy` still high) at L+1 -> IDLE at L+2; new grant can be decided at L+2, `bus_start` at L+3.
- Minimum turnaround: fill with back-to-back `bus_nib` = 8 nibbles + 3 cycles overhead = 11 cycles.
- `bus_nib` may have arbitrary gaps; counter and strobes only advance on `bus_nib=1`.

## Test plan

- Icache miss only: `ic_tag=0x12345`, `bus_nib` every cycle, `bus_rdata` 1..8 -> `bus_start` 1 cycle, `bus_addr=0x2468A`, `bus_len=8`, 8 `ic_wstrobe` pulses carrying 1..8, `ic_busy` low 2 cycles after last nibble.
- Load: `d_addr=0x00100`, nibbles 0xD,0xC,0xB,0xA -> `d_rdata=0xABCD`, `d_ack` one cycle after 4th nibble, `bus_write=0`, `bus_len=4`.
- Store: `d_wdata=0x1234`, `bus_nib` with one-cycle gaps -> `bus_wdata` sequence 4,3,2,1, `d_ack` once, `bus_write=1`.
- Simultaneous `ic_pull` and `d_req` from reset, both held -> icache granted first, data second, then alternation on repeat collisions.
- `ic_pull` dropped after 3 fill nibbles -> all 8 nibbles still strobed, `ic_busy` held through DONE.
- `reset_n` low during nibble 5 of a fill -> all outputs 0 immediately, state IDLE; after release a pending `d_req` is granted normally.

Source files
------------

// File: rtl/mem_sched.sv
// Nibble-serial memory scheduler: round-robin arbitration of icache line fills against
// 16-bit data loads/stores onto a single 4-bit memory engine, one transfer at a time.
module mem_sched #(
  parameter int unsigned LINE_LENGTH = 4,
  parameter int unsigned PA          = 22,
  parameter int unsigned NW          = $clog2(LINE_LENGTH * 2) + 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            ic_pull,
  input  logic [PA-1:$clog2(LINE_LENGTH)] ic_tag,
  output logic                            ic_busy,
  output logic [3:0]                      ic_dread,
  output logic                            ic_wstrobe,
  input  logic                            d_req,
  input  logic [PA-1:1]                   d_addr,
  input  logic                            d_write,
  input  logic [15:0]                     d_wdata,
  output logic [15:0]                     d_rdata,
  output logic                            d_ack,
  output logic                            bus_start,
  output logic [PA-1:1]                   bus_addr,
  output logic                            bus_write,
  output logic [NW-1:0]                   bus_len,
  output logic [3:0]                      bus_wdata,
  input  logic [3:0]                      bus_rdata,
  input  logic                            bus_nib
);

  localparam int unsigned LW = $clog2(LINE_LENGTH);
  localparam logic [NW-1:0] FillLen = NW'(LINE_LENGTH * 2);
  localparam logic [NW-1:0] DataLen = NW'(4);
  localparam logic [NW-1:0] NibOne  = NW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StIfill,
    StDread,
    StDwrite,
    StDone
  } state_e;

  state_e        r_state, w_state_next;
  logic          r_last;     // 1 = data was granted most recently
  logic          r_sel_ic;
  logic [PA-1:1] r_addr;
  logic          r_write;
  logic [NW-1:0] r_len;
  logic [NW-1:0] r_cnt;
  logic [15:0]   r_shift;
  logic [15:0]   r_rdata;

  logic          w_grant;
  logic          w_grant_ic;
  logic          w_xfer;
  logic          w_nib;
  logic          w_last_nib;
  logic [PA-1:1] w_line_addr;
  logic [15:0]   w_shift_in;

  // Halfword address of the first halfword in the missing line.
  assign w_line_addr = (PA - 1)'(ic_tag) << (LW - 1);

  assign w_grant_ic = ic_pull & (~d_req | r_last);
  assign w_xfer     = (r_state == StIfill) | (r_state == StDread) | (r_state == StDwrite);
  assign w_nib      = w_xfer & bus_nib;
  assign w_last_nib = (r_cnt == (r_len - NibOne));
  assign w_shift_in = {bus_rdata, r_shift[15:4]};

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    case (r_state)
      StIdle: begin
        if (ic_pull | d_req) begin
          w_grant      = 1'b1;
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        if (r_sel_ic) begin
          w_state_next = StIfill;
        end else if (r_write) begin
          w_state_next = StDwrite;
        end else begin
          w_state_next = StDread;
        end
      end
      StIfill, StDread, StDwrite: begin
        if (bus_nib && w_last_nib) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Command latched at grant stays put until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last   <= 1'b1;
      r_sel_ic <= 1'b0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_len    <= '0;
    end else if (w_grant) begin
      r_last   <= ~w_grant_ic;
      r_sel_ic <= w_grant_ic;
      if (w_grant_ic) begin
        r_addr  <= w_line_addr;
        r_write <= 1'b0;
        r_len   <= FillLen;
      end else begin
        r_addr  <= d_addr;
        r_write <= d_write;
        r_len   <= DataLen;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_grant) begin
      r_cnt <= '0;
    end else if (w_nib) begin
      r_cnt <= r_cnt + NibOne;
    end
  end

  // Loads assemble into r_shift and publish on the last nibble, so d_rdata stays stable
  // until a load completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_rdata <= '0;
    end else if (w_grant && !w_grant_ic) begin
      r_shift <= d_wdata;
    end else if (w_nib && (r_state == StDread)) begin
      r_shift <= w_shift_in;
      if (w_last_nib) begin
        r_rdata <= w_shift_in;
      end
    end else if (w_nib && (r_state == StDwrite)) begin
      r_shift <= {4'h0, r_shift[15:4]};
    end
  end

  always_comb begin
    ic_busy    = r_sel_ic & (r_state != StIdle);
    ic_wstrobe = (r_state == StIfill) & bus_nib;
    ic_dread   = (r_state == StIfill) ? bus_rdata : 4'h0;
    d_ack      = (r_state == StDone) & ~r_sel_ic;
    bus_start  = (r_state == StIssue);
    bus_wdata  = (r_state == StDwrite) ? r_shift[3:0] : 4'h0;
  end

  assign d_rdata   = r_rdata;
  assign bus_addr  = r_addr;
  assign bus_write = r_write;
  assign bus_len   = r_len;

endmodule

// File: tb/tb_mem_sched.sv
// Self-checking bench for mem_sched: directed scenarios plus randomized request mixes
// checked against a transaction-level reference model.
module tb_mem_sched;

  localparam int PA = 22;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ic_pull = 1'b0;
  logic [PA-1:2] ic_tag = '0;
  logic          ic_busy;
  logic [3:0]    ic_dread;
  logic          ic_wstrobe;
  logic          d_req = 1'b0;
  logic [PA-1:1] d_addr = '0;
  logic          d_write = 1'b0;
  logic [15:0]   d_wdata = '0;
  logic [15:0]   d_rdata;
  logic          d_ack;
  logic          bus_start;
  logic [PA-1:1] bus_addr;
  logic          bus_write;
  logic [NW-1:0] bus_len;
  logic [3:0]    bus_wdata;
  logic [3:0]    bus_rdata = '0;
  logic          bus_nib = 1'b0;

  mem_sched #(.LINE_LENGTH(4), .PA(PA)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ic_pull    (ic_pull),
    .ic_tag     (ic_tag),
    .ic_busy    (ic_busy),
    .ic_dread   (ic_dread),
    .ic_wstrobe (ic_wstrobe),
    .d_req      (d_req),
    .d_addr     (d_addr),
    .d_write    (d_write),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ack      (d_ack),
    .bus_start  (bus_start),
    .bus_addr   (bus_addr),
    .bus_write  (bus_write),
    .bus_len    (bus_len),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_nib    (bus_nib)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Nibbles the memory engine returns, in transfer order.
  logic [3:0] g_rd [8];

  // Observations of one transaction.
  int            c_starts, c_start_cycle, c_acks, c_ack_cycle, c_busy_cycles, c_last_nib;
  bit            c_timeout, c_busy_l1;
  logic [PA-1:1] c_addr;
  logic          c_write;
  logic [NW-1:0] c_len;
  logic [15:0]   c_rdata;
  logic [3:0]    c_strobe_q [$];
  logic [3:0]    c_wnib_q [$];

  // Reference model state.
  bit          m_last;   // 1 = data client granted most recently
  logic [15:0] m_rdata;

  task automatic do_reset();
    reset_n = 1'b0;
    ic_pull = 1'b0;
    d_req   = 1'b0;
    bus_nib = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_last  = 1'b1;
    m_rdata = '0;
  endtask

  task automatic fill_rd();
    for (int i = 0; i < 8; i++) g_rd[i] = 4'($urandom_range(0, 15));
  endtask

  // Memory-engine model: answers one command, records what the scheduler does.
  // gap_mode 0 = nibble every cycle, 1 = one-cycle gaps, 2 = random gaps.
  task automatic run_txn(input int gap_mode, input int drop_after, input bit is_ic,
                         input int exp_len);
    int rem;
    bit started;
    int nib_idx;
    int strobes;
    bit nib;
    bit deliver;
    c_starts = 0; c_start_cycle = -1; c_acks = 0; c_ack_cycle = -1;
    c_busy_cycles = 0; c_last_nib = -1; c_timeout = 1'b1; c_busy_l1 = 1'b0;
    c_addr = '0; c_write = 1'b0; c_len = '0; c_rdata = '0;
    c_strobe_q.delete();
    c_wnib_q.delete();
    rem = 0; started = 1'b0; nib_idx = 0; strobes = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (started && rem > 0) begin
        case (gap_mode)
          0:       nib = 1'b1;
          1:       nib = ((k - c_start_cycle) % 2) == 1;
          default: nib = $urandom_range(0, 2) != 0;
        endcase
      end else begin
        nib = 1'($urandom_range(0, 1));  // stray strobes outside a transfer
      end
      deliver   = started && rem > 0 && nib;
      bus_nib   = nib;
      bus_rdata = deliver ? g_rd[nib_idx] : 4'($urandom);
      #1;
      if (bus_start) begin
        c_starts++;
        if (!started) begin
          started = 1'b1; c_start_cycle = k;
          c_addr = bus_addr; c_write = bus_write; c_len = bus_len;
          rem = exp_len;
        end
      end
      if (ic_wstrobe) begin
        c_strobe_q.push_back(ic_dread);
        strobes++;
        if (strobes == drop_after) ic_pull = 1'b0;
      end
      if (d_ack) begin
        c_acks++; c_ack_cycle = k; c_rdata = d_rdata; d_req = 1'b0;
      end
      if (ic_busy) c_busy_cycles++;
      if (deliver) begin
        c_wnib_q.push_back(bus_wdata);
        rem--; nib_idx++;
        if (rem == 0) begin
          c_last_nib = k;
          if (is_ic) ic_pull = 1'b0;
        end
      end
      if (c_last_nib >= 0 && k == c_last_nib + 1) c_busy_l1 = ic_busy;
      if (c_last_nib >= 0 && k == c_last_nib + 2) begin
        c_timeout = 1'b0;
        break;
      end
    end
    bus_nib = 1'b0;
  endtask

  function automatic logic [31:0] pack_strobes();
    logic [31:0] v = '0;
    foreach (c_strobe_q[i]) if (i < 8) v[4*i +: 4] = c_strobe_q[i];
    return v;
  endfunction

  function automatic logic [15:0] pack_wnibs();
    logic [15:0] v = '0;
    foreach (c_wnib_q[i]) if (i < 4) v[4*i +: 4] = c_wnib_q[i];
    return v;
  endfunction

  function automatic logic [31:0] pack_rd();
    logic [31:0] v = '0;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = g_rd[i];
    return v;
  endfunction

  task automatic test_reset();
    logic [47:0] outs;
    reset_n = 1'b0; ic_pull = 1'b1; d_req = 1'b1; bus_nib = 1'b1; bus_rdata = 4'hF;
    ic_tag = '1; d_addr = '1; d_wdata = '1; d_write = 1'b1;
    #1;
    outs = {ic_busy, ic_wstrobe, ic_dread, d_ack, bus_start, bus_addr, bus_write, bus_len,
            bus_wdata};
    n_checks++;
    if (outs !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    n_checks++;
    if (d_rdata !== 16'h0) begin
      n_errors++; $display("FAIL reset_rdata: got %h want 0", d_rdata);
    end
    ic_pull = 1'b0; d_req = 1'b0; bus_nib = 1'b0; d_write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_last = 1'b1; m_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus_start !== 1'b0 || ic_busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_idle: got start=%b busy=%b want 0 0", bus_start, ic_busy);
    end
  endtask

  task automatic test_ifill();
    for (int i = 0; i < 8; i++) g_rd[i] = 4'(i + 1);
    ic_tag = 20'h12345; ic_pull = 1'b1;
    run_txn(0, -1, 1'b1, 8);
    n_checks++;
    if (c_starts !== 1 || c_start_cycle !== 0) begin
      n_errors++;
      $display("FAIL ifill_start: got %0d@%0d want 1@0", c_starts, c_start_cycle);
    end
    n_checks++;
    if (c_addr !== 21'h2468A || c_len !== 4'd8 || c_write !== 1'b0) begin
      n_errors++;
      $display("FAIL ifill_cmd: got addr=%h len=%0d wr=%b want 2468a 8 0", c_addr, c_len, c_write);
    end
    n_checks++;
    if (c_strobe_q.size() != 8 || pack_strobes() !== 32'h87654321) begin
      n_errors++;
      $display("FAIL ifill_strobes: got %0d/%h want 8/87654321", c_strobe_q.size(), pack_strobes());
    end
    n_checks++;
    if (c_last_nib !== 8 || c_busy_cycles !== 10 || c_busy_l1 !== 1'b1) begin
      n_errors++;
      $display("FAIL ifill_timing: got last=%0d busy=%0d busyL1=%b want 8 10 1", c_last_nib,
               c_busy_cycles, c_busy_l1);
    end
  endtask

  task automatic test_load();
    g_rd[0] = 4'hD; g_rd[1] = 4'hC; g_rd[2] = 4'hB; g_rd[3] = 4'hA;
    d_addr = 21'h00100; d_write = 1'b0; d_req = 1'b1;
    run_txn(0, -1, 1'b0, 4);
    m_rdata = 16'hABCD; m_last = 1'b1;
    n_checks++;
    if (c_addr !== 21'h00100 || c_len !== 4'd4 || c_write !== 1'b0 || c_starts !== 1) begin
      n_errors++;
      $display("FAIL load_cmd: got addr=%h len=%0d wr=%b n=%0d want 00100 4 0 1", c_addr, c_len,
               c_write, c_starts);
    end
    n_checks++;
    if (c_acks !== 1 || c_ack_cycle !== c_last_nib + 1 || c_rdata !== 16'hABCD) begin
      n_errors++;
      $display("FAIL load_ack: got n=%0d at=%0d rdata=%h want 1 %0d abcd", c_acks, c_ack_cycle,
               c_rdata, c_last_nib + 1);
    end
  endtask

  task automatic test_store();
    d_wdata = 16'h1234; d_write = 1'b1; d_addr = 21'($urandom); d_req = 1'b1;
    run_txn(1, -1, 1'b0, 4);
    d_write = 1'b0;
    n_checks++;
    if (c_write !== 1'b1 || c_len !== 4'd4 || c_addr !== d_addr) begin
      n_errors++;
      $display("FAIL store_cmd: got wr=%b len=%0d addr=%h want 1 4 %h", c_write, c_len, c_addr,
               d_addr);
    end
    n_checks++;
    if (c_wnib_q.size() != 4 || pack_wnibs() !== 16'h1234) begin
      n_errors++;
      $display("FAIL store_wdata: got %0d/%h want 4/1234", c_wnib_q.size(), pack_wnibs());
    end
    n_checks++;
    if (c_acks !== 1 || c_last_nib !== 7 || c_rdata !== m_rdata) begin
      n_errors++;
      $display("FAIL store_ack: got n=%0d last=%0d rdata=%h want 1 7 %h", c_acks, c_last_nib,
               c_rdata, m_rdata);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    ic_tag = 20'($urandom); d_addr = 21'($urandom); d_write = 1'b0;
    ic_pull = 1'b1; d_req = 1'b1;
    fill_rd(); run_txn(0, -1, 1'b1, 8);
    n_checks++;
    if (c_len !== 4'd8 || c_acks !== 0) begin
      n_errors++; $display("FAIL arb_first_ic: got len=%0d acks=%0d want 8 0", c_len, c_acks);
    end
    fill_rd(); run_txn(2, -1, 1'b0, 4);
    n_checks++;
    if (c_len !== 4'd4 || c_acks !== 1 || c_start_cycle !== 0) begin
      n_errors++;
      $display("FAIL arb_then_data: got len=%0d acks=%0d at=%0d want 4 1 0", c_len, c_acks,
               c_start_cycle);
    end
    ic_pull = 1'b1;
    fill_rd(); run_txn(2, -1, 1'b1, 8);
    ic_pull = 1'b1; d_req = 1'b1;
    fill_rd(); run_txn(0, -1, 1'b0, 4);
    n_checks++;
    if (c_len !== 4'd4 || c_acks !== 1) begin
      n_errors++; $display("FAIL arb_data_wins: got len=%0d acks=%0d want 4 1", c_len, c_acks);
    end
    fill_rd(); run_txn(0, -1, 1'b1, 8);
    n_checks++;
    if (c_len !== 4'd8 || c_start_cycle !== 0 || pack_strobes() !== pack_rd()) begin
      n_errors++;
      $display("FAIL arb_ic_after: got len=%0d at=%0d strb=%h want 8 0 %h", c_len, c_start_cycle,
               pack_strobes(), pack_rd());
    end
    m_last = 1'b0;
    m_rdata = {g_rd[3], g_rd[2], g_rd[1], g_rd[0]};  // overwritten below by directed reset
  endtask

  task automatic test_pull_drop();
    fill_rd();
    ic_tag = 20'($urandom); ic_pull = 1'b1;
    run_txn(0, 3, 1'b1, 8);
    n_checks++;
    if (c_strobe_q.size() != 8 || pack_strobes() !== pack_rd()) begin
      n_errors++;
      $display("FAIL pull_drop_strobes: got %0d/%h want 8/%h", c_strobe_q.size(), pack_strobes(),
               pack_rd());
    end
    n_checks++;
    if (c_busy_l1 !== 1'b1 || c_busy_cycles !== c_last_nib + 2) begin
      n_errors++;
      $display("FAIL pull_drop_busy: got L1=%b cycles=%0d want 1 %0d", c_busy_l1, c_busy_cycles,
               c_last_nib + 2);
    end
  endtask

  task automatic test_reset_midfill();
    logic [47:0] outs;
    do_reset();
    fill_rd();
    ic_tag = 20'($urandom); d_addr = 21'($urandom); d_write = 1'b0;
    ic_pull = 1'b1; d_req = 1'b1;
    @(negedge clk);
    bus_nib = 1'b0;
    #1;
    n_checks++;
    if (bus_start !== 1'b1 || bus_len !== 4'd8) begin
      n_errors++; $display("FAIL midrst_start: got %b len=%0d want 1 8", bus_start, bus_len);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus_nib = 1'b1; bus_rdata = g_rd[k];
    end
    #1;
    n_checks++;
    if (ic_wstrobe !== 1'b1 || ic_dread !== g_rd[4]) begin
      n_errors++;
      $display("FAIL midrst_nib5: got strb=%b d=%h want 1 %h", ic_wstrobe, ic_dread, g_rd[4]);
    end
    reset_n = 1'b0;
    #1;
    outs = {ic_busy, ic_wstrobe, ic_dread, d_ack, bus_start, bus_addr, bus_write, bus_len,
            bus_wdata};
    n_checks++;
    if (outs !== '0) begin
      n_errors++; $display("FAIL midrst_outputs: got %h want 0", outs);
    end
    ic_pull = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; bus_nib = 1'b0;
    m_last = 1'b1;
    fill_rd();
    run_txn(2, -1, 1'b0, 4);
    m_rdata = {g_rd[3], g_rd[2], g_rd[1], g_rd[0]};
    n_checks++;
    if (c_start_cycle !== 0 || c_addr !== d_addr || c_acks !== 1 || c_rdata !== m_rdata ||
        c_strobe_q.size() != 0) begin
      n_errors++;
      $display("FAIL midrst_data: got at=%0d addr=%h acks=%0d rdata=%h strb=%0d want 0 %h 1 %h 0",
               c_start_cycle, c_addr, c_acks, c_rdata, c_strobe_q.size(), d_addr, m_rdata);
    end
    m_last = 1'b1;
  endtask

  task automatic test_random();
    bit            pend_ic, pend_d, win_ic;
    int            pat;
    logic [PA-1:1] exp_addr;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      pat = $urandom_range(1, 3);
      pend_ic = pat[0]; pend_d = pat[1];
      ic_tag = 20'($urandom); d_addr = 21'($urandom);
      d_write = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
      ic_pull = pend_ic; d_req = pend_d;
      while (pend_ic || pend_d) begin
        win_ic = pend_ic && (!pend_d || m_last);
        fill_rd();
        run_txn($urandom_range(0, 2), -1, win_ic, win_ic ? 8 : 4);
        exp_addr = win_ic ? {ic_tag, 1'b0} : d_addr;
        n_checks++;
        if (c_timeout || c_starts !== 1 || c_start_cycle !== 0) begin
          n_errors++;
          $display("FAIL rnd_start it%0d: got to=%b n=%0d at=%0d want 0 1 0", it, c_timeout,
                   c_starts, c_start_cycle);
        end
        n_checks++;
        if (c_addr !== exp_addr || c_len !== (win_ic ? 4'd8 : 4'd4) ||
            c_write !== (win_ic ? 1'b0 : d_write)) begin
          n_errors++;
          $display("FAIL rnd_cmd it%0d: got addr=%h len=%0d wr=%b want %h %0d %b", it, c_addr,
                   c_len, c_write, exp_addr, win_ic ? 8 : 4, win_ic ? 1'b0 : d_write);
        end
        if (win_ic) begin
          n_checks++;
          if (c_strobe_q.size() != 8 || pack_strobes() !== pack_rd() || c_acks !== 0 ||
              c_busy_cycles !== c_last_nib + 2) begin
            n_errors++;
            $display("FAIL rnd_fill it%0d: got n=%0d d=%h acks=%0d busy=%0d want 8 %h 0 %0d", it,
                     c_strobe_q.size(), pack_strobes(), c_acks, c_busy_cycles, pack_rd(),
                     c_last_nib + 2);
          end
          pend_ic = 1'b0;
        end else begin
          if (!d_write) m_rdata = {g_rd[3], g_rd[2], g_rd[1], g_rd[0]};
          n_checks++;
          if (c_acks !== 1 || c_ack_cycle !== c_last_nib + 1 || c_rdata !== m_rdata ||
              c_busy_cycles !== 0 || c_strobe_q.size() != 0) begin
            n_errors++;
            $display("FAIL rnd_data it%0d: got acks=%0d at=%0d rdata=%h busy=%0d want 1 %0d %h 0",
                     it, c_acks, c_ack_cycle, c_rdata, c_busy_cycles, c_last_nib + 1, m_rdata);
          end
          if (d_write) begin
            n_checks++;
            if (pack_wnibs() !== d_wdata) begin
              n_errors++;
              $display("FAIL rnd_wdata it%0d: got %h want %h", it, pack_wnibs(), d_wdata);
            end
          end
          pend_d = 1'b0;
        end
        m_last = !win_ic;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_last = 1'b1;
    m_rdata = '0;
    test_reset();
    test_ifill();
    test_load();
    test_store();
    test_arbitration();
    test_pull_drop();
    test_reset_midfill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
